// File: rtl/int_csr_pkg.sv
// Shared definitions for the interrupt CSR bank: CSR map, STATUS bit positions and
// trap sequencer state encoding.
package int_csr_pkg;

  localparam int unsigned CSR_AW     = 3;
  localparam int unsigned STATUS_W   = 8;
  localparam int unsigned CAUSE_ID_W = 3;

  localparam logic [CSR_AW-1:0] CSR_STATUS  = 3'd0;
  localparam logic [CSR_AW-1:0] CSR_PENDING = 3'd1;
  localparam logic [CSR_AW-1:0] CSR_INTMASK = 3'd2;
  localparam logic [CSR_AW-1:0] CSR_EPC     = 3'd3;
  localparam logic [CSR_AW-1:0] CSR_TVEC    = 3'd4;
  localparam logic [CSR_AW-1:0] CSR_CAUSE   = 3'd5;

  localparam int unsigned ST_IE  = 0;
  localparam int unsigned ST_EXL = 1;
  localparam int unsigned ST_PIE = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ENTRY   = 2'd1,
    HANDLER = 2'd2,
    RETURN  = 2'd3
  } state_e;

endpackage

// File: rtl/int_csr_file_irq_edge_latch.sv
// Rising-edge detector and sticky pending register for the external IRQ lines.
// A new edge always beats a software or trap-entry clear in the same cycle.
module irq_edge_latch #(
  parameter int unsigned NUM_IRQ = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] i_irq,
  input  logic [NUM_IRQ-1:0] i_w1c,
  input  logic [NUM_IRQ-1:0] i_ack,
  output logic [NUM_IRQ-1:0] o_pend
);

  logic [NUM_IRQ-1:0] r_prev;
  logic [NUM_IRQ-1:0] r_pend;
  logic [NUM_IRQ-1:0] w_rise;

  assign w_rise = i_irq & ~r_prev;
  assign o_pend = r_pend;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev <= '0;
      r_pend <= '0;
    end else begin
      r_prev <= i_irq;
      r_pend <= (r_pend & ~i_w1c & ~i_ack) | w_rise;
    end
  end

endmodule

// File: rtl/int_csr_file.sv
// Interrupt CSR bank with trap entry/return sequencer; issues one-cycle fetch
// redirects to TVEC on entry and to EPC on return.
module int_csr_file
  import int_csr_pkg::*;
#(
  parameter int unsigned      NUM_IRQ    = 8,
  parameter int unsigned      XLEN       = 32,
  parameter logic [XLEN-1:0]  TVEC_RESET = 32'h0000_0100
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               csr_we,
  input  logic [2:0]         csr_addr,
  input  logic [XLEN-1:0]    csr_wdata,
  output logic [XLEN-1:0]    csr_rdata,
  output logic [7:0]         status_o,
  output logic [NUM_IRQ-1:0] scause_o,
  output logic [NUM_IRQ-1:0] intmask_o,
  input  logic               exl_set,
  input  logic [2:0]         int_pend,
  input  logic [XLEN-1:0]    trap_pc,
  input  logic               eret,
  output logic               redirect_valid,
  output logic [XLEN-1:0]    redirect_pc
);

  state_e             r_state;
  state_e             w_state_nxt;
  logic [STATUS_W-1:0] r_status;
  logic [STATUS_W-1:0] w_status_nxt;
  logic [NUM_IRQ-1:0] r_intmask;
  logic [NUM_IRQ-1:0] w_intmask_nxt;
  logic [XLEN-1:0]    r_epc;
  logic [XLEN-1:0]    w_epc_nxt;
  logic [XLEN-1:0]    r_tvec;
  logic [XLEN-1:0]    w_tvec_nxt;
  logic               r_cause_vld;
  logic [CAUSE_ID_W-1:0] r_cause_id;
  logic               r_redirect_valid;
  logic [XLEN-1:0]    r_redirect_pc;

  logic               w_trap_entry;
  logic               w_trap_ret;
  logic               w_we_status;
  logic               w_we_pending;
  logic               w_we_intmask;
  logic               w_we_epc;
  logic               w_we_tvec;
  logic [NUM_IRQ-1:0] w_w1c;
  logic [NUM_IRQ-1:0] w_ack;
  logic [NUM_IRQ-1:0] w_pend;

  assign w_we_status  = csr_we && (csr_addr == CSR_STATUS);
  assign w_we_pending = csr_we && (csr_addr == CSR_PENDING);
  assign w_we_intmask = csr_we && (csr_addr == CSR_INTMASK);
  assign w_we_epc     = csr_we && (csr_addr == CSR_EPC);
  assign w_we_tvec    = csr_we && (csr_addr == CSR_TVEC);

  assign w_w1c = w_we_pending ? csr_wdata[NUM_IRQ-1:0] : '0;
  assign w_ack = w_trap_entry ? (NUM_IRQ'(1) << int_pend) : '0;

  irq_edge_latch #(.NUM_IRQ(NUM_IRQ)) u_edge_latch (
    .clk    (clk),
    .rst    (rst),
    .i_irq  (irq_in),
    .i_w1c  (w_w1c),
    .i_ack  (w_ack),
    .o_pend (w_pend)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Sequencer: exl_set only honoured in IDLE, eret only in HANDLER
  always_comb begin
    w_state_nxt  = r_state;
    w_trap_entry = 1'b0;
    w_trap_ret   = 1'b0;
    case (r_state)
      IDLE: begin
        if (exl_set) begin
          w_trap_entry = 1'b1;
          w_state_nxt  = ENTRY;
        end
      end
      ENTRY:   w_state_nxt = HANDLER;
      HANDLER: begin
        if (eret) begin
          w_trap_ret  = 1'b1;
          w_state_nxt = RETURN;
        end
      end
      RETURN:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Trap entry overrides SW on STATUS/EPC; on return SW keeps every bit except IE/EXL
  always_comb begin
    w_status_nxt  = w_we_status  ? csr_wdata[STATUS_W-1:0] : r_status;
    w_intmask_nxt = w_we_intmask ? csr_wdata[NUM_IRQ-1:0]  : r_intmask;
    w_epc_nxt     = w_we_epc     ? csr_wdata               : r_epc;
    w_tvec_nxt    = w_we_tvec    ? csr_wdata               : r_tvec;
    if (w_trap_entry) begin
      w_status_nxt         = r_status;
      w_status_nxt[ST_PIE] = r_status[ST_IE];
      w_status_nxt[ST_IE]  = 1'b0;
      w_status_nxt[ST_EXL] = 1'b1;
      w_epc_nxt            = trap_pc;
    end else if (w_trap_ret) begin
      w_status_nxt[ST_IE]  = r_status[ST_PIE];
      w_status_nxt[ST_EXL] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_status         <= '0;
      r_intmask        <= '0;
      r_epc            <= '0;
      r_tvec           <= TVEC_RESET;
      r_cause_vld      <= 1'b0;
      r_cause_id       <= '0;
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= '0;
    end else begin
      r_status         <= w_status_nxt;
      r_intmask        <= w_intmask_nxt;
      r_epc            <= w_epc_nxt;
      r_tvec           <= w_tvec_nxt;
      r_redirect_valid <= w_trap_entry | w_trap_ret;
      if (w_trap_entry) begin
        r_cause_vld <= 1'b1;
        r_cause_id  <= int_pend;
      end
      if (w_trap_entry)    r_redirect_pc <= w_tvec_nxt;
      else if (w_trap_ret) r_redirect_pc <= w_epc_nxt;
      else                 r_redirect_pc <= '0;
    end
  end

  always_comb begin
    csr_rdata = '0;
    case (csr_addr)
      CSR_STATUS:  csr_rdata = XLEN'(r_status);
      CSR_PENDING: csr_rdata = XLEN'(w_pend);
      CSR_INTMASK: csr_rdata = XLEN'(r_intmask);
      CSR_EPC:     csr_rdata = r_epc;
      CSR_TVEC:    csr_rdata = r_tvec;
      CSR_CAUSE: begin
        csr_rdata[XLEN-1]         = r_cause_vld;
        csr_rdata[CAUSE_ID_W-1:0] = r_cause_id;
      end
      default:     csr_rdata = '0;
    endcase
  end

  assign status_o       = r_status;
  assign scause_o       = w_pend;
  assign intmask_o      = r_intmask;
  assign redirect_valid = r_redirect_valid;
  assign redirect_pc    = r_redirect_pc;

endmodule

// File: tb/tb_int_csr_file.sv
// Bench for int_csr_file: directed scenarios with literal expectations, then random
// traffic compared every cycle against a register-level behavioural model.
module tb_int_csr_file;

  logic        clk;
  logic        rst;
  logic [7:0]  irq_in;
  logic        csr_we;
  logic [2:0]  csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic [7:0]  status_o;
  logic [7:0]  scause_o;
  logic [7:0]  intmask_o;
  logic        exl_set;
  logic [2:0]  int_pend;
  logic [31:0] trap_pc;
  logic        eret;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  int_csr_file dut (
    .clk(clk), .rst(rst), .irq_in(irq_in),
    .csr_we(csr_we), .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_rdata(csr_rdata),
    .status_o(status_o), .scause_o(scause_o), .intmask_o(intmask_o),
    .exl_set(exl_set), .int_pend(int_pend), .trap_pc(trap_pc), .eret(eret),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state: phase 0=idle, 1=entry, 2=handler, 3=return
  logic [7:0]  m_status, m_pend, m_prev, m_mask;
  logic [31:0] m_epc, m_tvec, m_cause, m_rpc;
  logic        m_rv;
  int          m_phase;
  bit          chk_en;
  int          n_chk;
  int          n_pass;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] model_rd(input logic [2:0] a);
    case (a)
      3'd0:    return {24'h0, m_status};
      3'd1:    return {24'h0, m_pend};
      3'd2:    return {24'h0, m_mask};
      3'd3:    return m_epc;
      3'd4:    return m_tvec;
      3'd5:    return m_cause;
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_step();
    logic [7:0]  rise, w1c, ack, st_n;
    logic [31:0] epc_n, tvec_n;
    int          ph_n;
    if (rst) begin
      m_status = 0; m_pend = 0; m_prev = 0; m_mask = 0;
      m_epc = 0; m_tvec = 32'h100; m_cause = 0;
      m_rv = 0; m_rpc = 0; m_phase = 0;
      return;
    end
    rise   = irq_in & ~m_prev;
    w1c    = (csr_we && csr_addr == 3'd1) ? csr_wdata[7:0] : 8'h0;
    ack    = 8'h0;
    st_n   = (csr_we && csr_addr == 3'd0) ? csr_wdata[7:0] : m_status;
    epc_n  = (csr_we && csr_addr == 3'd3) ? csr_wdata : m_epc;
    tvec_n = (csr_we && csr_addr == 3'd4) ? csr_wdata : m_tvec;
    if (csr_we && csr_addr == 3'd2) m_mask = csr_wdata[7:0];
    m_rv  = 0;
    m_rpc = 0;
    ph_n  = m_phase;
    if (m_phase == 0 && exl_set) begin
      ack     = 8'd1 << int_pend;
      epc_n   = trap_pc;
      m_cause = 32'h8000_0000 + {29'h0, int_pend};
      st_n    = {m_status[7:3], m_status[0], 1'b1, 1'b0};
      ph_n    = 1;
      m_rv    = 1;
      m_rpc   = tvec_n;
    end else if (m_phase == 1) begin
      ph_n = 2;
    end else if (m_phase == 2 && eret) begin
      st_n  = {st_n[7:2], 1'b0, m_status[2]};
      ph_n  = 3;
      m_rv  = 1;
      m_rpc = epc_n;
    end else if (m_phase == 3) begin
      ph_n = 0;
    end
    m_pend   = (m_pend & ~w1c & ~ack) | rise;
    m_prev   = irq_in;
    m_status = st_n;
    m_epc    = epc_n;
    m_tvec   = tvec_n;
    m_phase  = ph_n;
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
    #1;
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("status_o", {24'h0, status_o}, {24'h0, m_status});
      check("scause_o", {24'h0, scause_o}, {24'h0, m_pend});
      check("intmask_o", {24'h0, intmask_o}, {24'h0, m_mask});
      check("redirect_valid", {31'h0, redirect_valid}, {31'h0, m_rv});
      if (m_rv) check("redirect_pc", redirect_pc, m_rpc);
      check("csr_rdata", csr_rdata, model_rd(csr_addr));
    end
  end

  initial begin
    n_chk = 0; n_pass = 0; chk_en = 0;
    rst = 1; irq_in = 0; csr_we = 0; csr_addr = 0; csr_wdata = 0;
    exl_set = 0; int_pend = 0; trap_pc = 0; eret = 0;
    step();
    chk_en = 1;
    step();
    check("rst_redirect_valid", {31'h0, redirect_valid}, 32'h0);
    check("rst_status", {24'h0, status_o}, 32'h0);
    csr_addr = 3'd4; #1;
    check("rst_tvec", csr_rdata, 32'h100);
    rst = 0;

    // Edge latch, W1C with line still high
    irq_in = 8'h04;
    step();
    check("edge_set", {24'h0, scause_o}, 32'h04);
    repeat (4) step();
    check("edge_hold", {24'h0, scause_o}, 32'h04);
    csr_we = 1; csr_addr = 3'd1; csr_wdata = 32'h04;
    step();
    csr_we = 0;
    check("w1c_clear", {24'h0, scause_o}, 32'h0);
    step(); step();
    check("no_reset_level", {24'h0, scause_o}, 32'h0);

    // Trap entry
    csr_we = 1; csr_addr = 3'd0; csr_wdata = 32'h01;
    step();
    csr_we = 0;
    irq_in = 8'h00; step();
    irq_in = 8'h04; step();
    check("pend_bit2", {24'h0, scause_o}, 32'h04);
    exl_set = 1; int_pend = 3'd2; trap_pc = 32'h40;
    step();
    check("entry_status", {24'h0, status_o}, 32'h06);
    check("entry_ack", {24'h0, scause_o}, 32'h0);
    check("entry_rv", {31'h0, redirect_valid}, 32'h1);
    check("entry_rpc", redirect_pc, 32'h100);
    trap_pc = 32'h99;
    csr_addr = 3'd3; #1;
    check("entry_epc", csr_rdata, 32'h40);
    csr_addr = 3'd5; #1;
    check("entry_cause", csr_rdata, 32'h8000_0002);
    step(); step();
    exl_set = 0;
    csr_addr = 3'd3; #1;
    check("no_second_capture", csr_rdata, 32'h40);
    check("handler_rv", {31'h0, redirect_valid}, 32'h0);

    // Return
    eret = 1;
    step();
    eret = 0;
    check("ret_status", {24'h0, status_o}, 32'h05);
    check("ret_rv", {31'h0, redirect_valid}, 32'h1);
    check("ret_rpc", redirect_pc, 32'h40);
    step();
    check("ret_done", {31'h0, redirect_valid}, 32'h0);

    // Rising edge beats W1C in the same cycle
    irq_in = 8'h0C; csr_we = 1; csr_addr = 3'd1; csr_wdata = 32'h08;
    step();
    csr_we = 0;
    check("set_wins", {31'h0, scause_o[3]}, 32'h1);

    // SW rewrites EPC in handler
    exl_set = 1; int_pend = 3'd3; trap_pc = 32'h44;
    step();
    exl_set = 0;
    step();
    csr_we = 1; csr_addr = 3'd3; csr_wdata = 32'h80;
    step();
    csr_we = 0; eret = 1;
    step();
    eret = 0;
    check("sw_epc_rv", {31'h0, redirect_valid}, 32'h1);
    check("sw_epc_rpc", redirect_pc, 32'h80);
    step();

    // Reset during ENTRY drops the redirect
    csr_we = 1; csr_addr = 3'd4; csr_wdata = 32'h200;
    step();
    csr_we = 0; exl_set = 1; int_pend = 3'd1; trap_pc = 32'h60;
    step();
    exl_set = 0;
    check("tvec_rpc", redirect_pc, 32'h200);
    rst = 1;
    step();
    rst = 0;
    check("rst_drop_rv", {31'h0, redirect_valid}, 32'h0);
    check("rst_drop_status", {24'h0, status_o}, 32'h0);
    csr_addr = 3'd4; #1;
    check("rst_drop_tvec", csr_rdata, 32'h100);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 3) == 0) irq_in = 8'($urandom);
      csr_we    = ($urandom_range(0, 2) == 0);
      csr_addr  = 3'($urandom);
      csr_wdata = $urandom;
      exl_set   = ($urandom_range(0, 5) == 0);
      int_pend  = 3'($urandom);
      trap_pc   = $urandom;
      eret      = ($urandom_range(0, 4) == 0);
      step();
    end

    chk_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
